// File: rtl/nonce_scheduler.sv
// Nonce sweep scheduler: hands nonces to free hash cores and round-robin
// arbitrates their finished H0 results onto the single memory write port.
//
// state | meaning
// IDLE  | waiting for start; cores free, no traffic
// RUN   | dispatching nonces and writing back results concurrently
// FIN   | one-cycle done pulse, then back to IDLE
module nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic                    mem_clk,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic [NUM_CORES-1:0]    core_ack
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [8:0] LAST_CNT = 9'(NUM_NONCES);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] busy, busy_nxt;
  logic [8:0]           nonce_reg [NUM_CORES];
  logic [8:0]           nonce_reg_nxt [NUM_CORES];
  logic [8:0]           next_nonce, next_nonce_nxt;
  logic [8:0]           written, written_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [15:0]          base_addr, base_addr_nxt;

  logic                 done_nxt, mem_we_nxt;
  logic [15:0]          mem_addr_nxt;
  logic [31:0]          mem_write_data_nxt, core_nonce_nxt;
  logic [NUM_CORES-1:0] core_start_nxt, core_ack_nxt;

  logic [NUM_CORES-1:0] cand, disp_oh, grant_oh;
  logic                 disp_ok, grant_ok;
  logic [PTR_W-1:0]     rr_next, sel;
  logic [8:0]           grant_nonce;
  logic [31:0]          grant_h0;
  int                   scan;

  assign mem_clk = clk;

  // Core selection: lowest free core for dispatch, rotating search for grant.
  always_comb begin
    cand    = core_done & busy;
    disp_ok = 1'b0;
    disp_oh = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        disp_ok    = 1'b1;
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
      end
    end

    grant_ok    = 1'b0;
    grant_oh    = '0;
    rr_next     = rr_ptr;
    scan        = 0;
    sel         = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_CORES) scan = scan - NUM_CORES;
      sel = PTR_W'(scan);
      if (!grant_ok && cand[sel]) begin
        grant_ok      = 1'b1;
        grant_oh[sel] = 1'b1;
        rr_next       = (scan == NUM_CORES - 1) ? '0 : PTR_W'(scan + 1);
      end
    end

    grant_nonce = '0;
    grant_h0    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) begin
        grant_nonce = nonce_reg[i];
        grant_h0    = core_h0[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    busy_nxt           = busy;
    nonce_reg_nxt      = nonce_reg;
    next_nonce_nxt     = next_nonce;
    written_nxt        = written;
    rr_ptr_nxt         = rr_ptr;
    base_addr_nxt      = base_addr;
    done_nxt           = 1'b0;
    mem_we_nxt         = 1'b0;
    mem_addr_nxt       = mem_addr;
    mem_write_data_nxt = mem_write_data;
    core_start_nxt     = '0;
    core_nonce_nxt     = core_nonce;
    core_ack_nxt       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          base_addr_nxt  = output_addr;
          next_nonce_nxt = '0;
          written_nxt    = '0;
          state_nxt      = RUN;
        end
      end
      RUN: begin
        if (next_nonce < LAST_CNT && disp_ok) begin
          core_start_nxt = disp_oh;
          core_nonce_nxt = {23'd0, next_nonce};
          next_nonce_nxt = next_nonce + 9'd1;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (disp_oh[i]) nonce_reg_nxt[i] = next_nonce;
          end
        end
        if (grant_ok) begin
          mem_we_nxt         = 1'b1;
          mem_addr_nxt       = base_addr + {7'd0, grant_nonce};
          mem_write_data_nxt = grant_h0;
          core_ack_nxt       = grant_oh;
          written_nxt        = written + 9'd1;
          rr_ptr_nxt         = rr_next;
        end
        // Dispatch needs FREE and grant needs BUSY, so the two masks never overlap.
        busy_nxt = (busy | core_start_nxt) & ~core_ack_nxt;
        if (written == LAST_CNT) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= '0;
      for (int i = 0; i < NUM_CORES; i++) nonce_reg[i] <= '0;
      next_nonce     <= '0;
      written        <= '0;
      rr_ptr         <= '0;
      base_addr      <= '0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      core_start     <= '0;
      core_nonce     <= '0;
      core_ack       <= '0;
    end else begin
      state          <= state_nxt;
      busy           <= busy_nxt;
      nonce_reg      <= nonce_reg_nxt;
      next_nonce     <= next_nonce_nxt;
      written        <= written_nxt;
      rr_ptr         <= rr_ptr_nxt;
      base_addr      <= base_addr_nxt;
      done           <= done_nxt;
      mem_we         <= mem_we_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
      core_start     <= core_start_nxt;
      core_nonce     <= core_nonce_nxt;
      core_ack       <= core_ack_nxt;
    end
  end

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequences the bitcoin-hash nonce sweep across NUM_CORES parallel SHA-256 second-pass cores.
- Hands out nonces 0..NUM_NONCES-1 to free cores and tracks which nonce each core holds.
- Round-robin arbitrates the single memory write port among finished cores, writing H0 of each result to output_addr + nonce.
- Sits between the top-level start/done handshake and the core array; it does no hashing itself.

Parameters:
- NUM_CORES, 4, number of hash cores (1..16).
- NUM_NONCES, 16, nonces per job (1..256).

Ports:
- clk  in  1  clock; also drives mem_clk
- reset  in  1  synchronous, active-high reset
- start  in  1  job start; sampled only in IDLE
- output_addr  in  16  base address for results
- done  out  1  one-cycle pulse: all NUM_NONCES results written
- mem_clk  out  1  equals clk
- mem_we  out  1  memory write enable
- mem_addr  out  16  write address
- mem_write_data  out  32  write data (H0)
- core_start  out  NUM_CORES  one-hot, one-cycle dispatch pulse
- core_nonce  out  32  nonce for the core pulsed in core_start; valid only with the pulse
- core_done  in  NUM_CORES  level; core i holds its result until acked
- core_h0  in  NUM_CORES*32  core i H0 in bits [32i+31:32i]
- core_ack  out  NUM_CORES  one-hot, one-cycle pulse: result consumed

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: done, mem_we, core_start, core_ack = 0; mem_addr, mem_write_data, core_nonce = 0.
  - State: IDLE; all cores FREE; next_nonce = 0; written = 0; rr_ptr = 0.
  - Reset asserted mid-job aborts the job immediately. In-flight core results are abandoned and later core_done is ignored until that core is dispatched again.
- States:
  - IDLE: start=1 latches output_addr, clears counters, then RUN.
  - RUN: dispatch and writeback run concurrently. Go to FIN when written == NUM_NONCES.
  - FIN: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- Per-core status is FREE or BUSY, and each core has a stored nonce register.
- Dispatch (RUN, at most one per cycle):
  - Condition: next_nonce < NUM_NONCES and some core is FREE. Target is the lowest-index FREE core.
  - Registered outputs: core_start[i]=1, core_nonce=next_nonce. Core i becomes BUSY and its nonce register = next_nonce; next_nonce increments.
  - First dispatch occurs the cycle after start is sampled, i.e. core_start is visible at cycle N+1 when start is sampled at edge N.
- Writeback (RUN, at most one per cycle):
  - Candidates: core_done[i] & BUSY[i].
  - Grant is round-robin: search begins at rr_ptr, wrapping modulo NUM_CORES. After granting i, rr_ptr = (i+1) mod NUM_CORES.
  - Registered outputs: mem_we=1, mem_addr=saved_output_addr + nonce_of_core_i (16-bit wrap), mem_write_data = core_h0 slice i, core_ack[i]=1.
  - Core i returns to FREE on the same edge. It is not re-dispatchable until the following cycle, because the dispatch decision uses pre-edge status.
  - written increments on each grant.
- Simultaneous dispatch and writeback in one cycle are allowed. They never target the same core, since dispatch needs FREE and grant needs BUSY.
- core_done on a FREE core is ignored: no write, no ack.
- mem_we, core_start and core_ack are 0 in every cycle with no grant or dispatch.
- Counters are 9 bits wide, so NUM_NONCES=256 fits. The core nonce register is 32 bits with the upper bits zero.
- Completion: done pulses one cycle after the final write cycle. mem_we is 0 during the done cycle.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0. start held high with reset=1 -> no dispatch.
- NUM_CORES=4, NUM_NONCES=16, output_addr=16'h0100, cores respond a fixed 10 cycles after start with h0=nonce^32'hA5A5A5A5:
  - Exactly 16 writes, addresses 0x0100..0x010F each once, data matching per nonce.
  - Exactly 16 core_start pulses, no nonce repeated.
  - done pulses once, then IDLE.
- Cores 0..3 raise core_done in the same cycle:
  - Grants are spaced one per cycle in order 0,1,2,3 (rr_ptr=0).
  - Next simultaneous burst after granting core 3 starts from core 0. If rr_ptr=2, order is 2,3,0,1.
- Single-core stall: core 1 never raises core_done. Others recycle; written saturates at 15; done is never asserted.
- Reset asserted mid-RUN after 5 writes:
  - Next cycle all outputs 0 and state IDLE. A stale core_done is ignored with no ack.
  - New start restarts at nonce 0.
- start pulsed during RUN -> no effect. NUM_NONCES=1, NUM_CORES=1 -> single dispatch, single write at output_addr, done.
